// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// default / simulation-scale timing constants.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Board-scale timing
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_REPEAT_PERIOD   = 25_000_000;

    // Short timing so simulations stay small
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_REPEAT_PERIOD   = 8;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous pushbutton line into the
// clock domain. Both flops clear to 0 on Reset.
module sync_2ff (
    input  logic clock,
    input  logic Reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // The first flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clock) begin
        if (Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: synchronizes the raw button, requires DEBOUNCE_CYCLES+1
// consecutive equal synchronized samples before accepting a level change, and
// emits registered one-cycle press/release pulses plus the debounced level.
// Optional auto-repeat of press_pulse while held: define BUTTON_AUTO_REPEAT_EN.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clock,
    input  logic Reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_debouncer: DEBOUNCE_CYCLES and REPEAT_PERIOD must be at least 1");
    end

    logic             btn_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_fire;

    sync_2ff u_sync (
        .clock (clock),
        .Reset (Reset),
        .d_i   (btn_in),
        .q_o   (btn_s)
    );

    // The stability counter never wraps: it holds at its terminal value.
    assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);

    // State and stability-counter registers; reset discards any debounce in progress.
    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a wait state returns on any contrary sample, advances after a full stable run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_PERIOD + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_q, rep_d;

    // Count held cycles in PRESSED; any other state or a low sample parks the counter at 0.
    always_comb begin
        rep_d       = '0;
        repeat_fire = 1'b0;
        if (state_q == PRESSED && btn_s) begin
            if (rep_q == REP_LAST) begin
                repeat_fire = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    // Repeat counter register.
    always_ff @(posedge clock) begin
        if (Reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // Outputs: pulses and level change together on the edge that completes a stable run.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        level_d   = level_q;
        if (state_q == PRESS_WAIT && btn_s && cnt_q == CNT_LAST) begin
            press_d = 1'b1;
            level_d = 1'b1;
        end
        if (state_q == RELEASE_WAIT && !btn_s && cnt_q == CNT_LAST) begin
            release_d = 1'b1;
            level_d   = 1'b0;
        end
        if (repeat_fire) begin
            press_d = 1'b1;
        end
    end

    // Output registers keep the pulses glitch-free for the downstream counter enable.
    always_ff @(posedge clock) begin
        if (Reset) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer at simulation scale (DEBOUNCE_CYCLES=4,
// REPEAT_PERIOD=8). A run-length model of the debouncing rules is compared
// with the DUT every cycle; directed windows carry hand-derived expectations.
// Honours BUTTON_AUTO_REPEAT_EN the same way as the design.
module tb_button_debouncer;
    import button_pkg::*;

    localparam int D = SIM_DEBOUNCE_CYCLES;
    localparam int R = SIM_REPEAT_PERIOD;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clock  = 1'b0;
    logic Reset  = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_PERIOD   (R)
    ) dut (
        .clock         (clock),
        .Reset         (Reset),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a level flips once the synchronized input has disagreed
    // with it for D+1 consecutive samples; while held high after acceptance,
    // every R-th agreeing sample produces a repeat press.
    bit m_s1, m_s2, m_bs;
    bit m_lvl, m_prs, m_rel;
    int m_run, m_rep;

    always @(posedge clock) begin
        if (Reset) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prs = 0; m_rel = 0;
            m_run = 0; m_rep = 0;
        end else begin
            m_bs = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_in;
            m_prs = 0;
            m_rel = 0;
            if (m_bs != m_lvl) begin
                m_run++;
                m_rep = 0;
                if (m_run == D + 1) begin
                    m_lvl = m_bs;
                    m_prs = m_bs;
                    m_rel = !m_bs;
                    m_run = 0;
                end
            end else begin
                if (REP_ON && m_lvl && m_run == 0) begin
                    m_rep++;
                    if (m_rep == R) begin
                        m_prs = 1;
                        m_rep = 0;
                    end
                end else begin
                    m_rep = 0;
                end
                m_run = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clock) begin
        #2;
        check("model_level", btn_level, m_lvl);
        check("model_press", press_pulse, m_prs);
        check("model_release", release_pulse, m_rel);
    end

    function automatic logic [63:0] run_mask(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i < hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bit_at(input int k);
        logic [63:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    // Edge k of a window samples btn_pat[k]/rst_pat[k]; outputs are checked just after it.
    task automatic window(input string tag, input int n,
                          input logic [63:0] btn_pat, input logic [63:0] rst_pat,
                          input logic [63:0] p_exp, input logic [63:0] r_exp,
                          input logic [63:0] l_exp);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            btn_in = btn_pat[k];
            Reset  = rst_pat[k];
            @(posedge clock);
            #2;
            check($sformatf("%s_press[%0d]", tag, k), press_pulse, p_exp[k]);
            check($sformatf("%s_release[%0d]", tag, k), release_pulse, r_exp[k]);
            check($sformatf("%s_level[%0d]", tag, k), btn_level, l_exp[k]);
        end
    endtask

    initial begin
        logic [63:0] rep_w2;
        logic [63:0] rep_w8;
        rep_w2 = REP_ON ? bit_at(14) : 64'd0;
        rep_w8 = REP_ON ? (bit_at(14) | bit_at(22) | bit_at(30)) : 64'd0;

        // Reset held 3 cycles, then 20 quiet cycles
        window("reset", 23, 64'd0, run_mask(0, 3), 64'd0, 64'd0, 64'd0);

        // Clean press: pulse after edge 6, level high from then on
        window("press", 20, run_mask(0, 20), 64'd0,
               bit_at(6) | rep_w2, 64'd0, run_mask(6, 20));

        // Clean release: pulse 6 edges after the falling input
        window("release", 14, 64'd0, 64'd0, 64'd0, bit_at(6), run_mask(0, 6));

        // Bounce 1,0,1,0 with 2-cycle widths
        window("bounce", 16, 64'h33, 64'd0, 64'd0, 64'd0, 64'd0);

        // Glitch of D synchronized samples is rejected
        window("glitch4", 12, run_mask(0, 4), 64'd0, 64'd0, 64'd0, 64'd0);

        // D+1 samples is just enough: press at 6, release at 11
        window("glitch5", 16, run_mask(0, 5), 64'd0,
               bit_at(6), bit_at(11), run_mask(6, 11));

        // Reset during PRESS_WAIT with button held; press 6 edges after deassertion
        window("rst_mid", 30, run_mask(0, 17), bit_at(3) | bit_at(4),
               bit_at(11), bit_at(23), run_mask(11, 23));

        // Long hold: repeats every R cycles when enabled, none otherwise
        window("hold", 50, run_mask(0, 36), 64'd0,
               bit_at(6) | rep_w8, bit_at(42), run_mask(6, 42));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
